// File: rtl/result_drain.sv
// Result drain: collects N_RES accumulator results from the MAC array into a
// local buffer, then streams them out saturated to OUT_W bits over a
// valid/ready handshake, pulsing done once the last one has been accepted.
module result_drain #(
  parameter int ACC_W = 18,
  parameter int OUT_W = 16,
  parameter int N_RES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [3:0]       dout_idx,
  output logic             dout_last,
  output logic             busy,
  output logic             done,
  output logic             overflow_err
);

  localparam int IDX_W = (N_RES <= 2) ? 1 : $clog2(N_RES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RES - 1);
  localparam logic [OUT_W-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] res_buf [N_RES];
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_cnt;
  logic [ACC_W-1:0] rd_word;
  logic             rd_last;
  logic             wr_last;

  assign rd_word = res_buf[rd_cnt];
  assign rd_last = (rd_cnt == LAST_IDX);
  assign wr_last = (wr_cnt == LAST_IDX);

  // State register; reset abandons any collection or drain in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: clear wins over everything, DONE lasts exactly one cycle.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (acc_valid) state_next = COLLECT;
        COLLECT: if (acc_valid && wr_last) state_next = DRAIN;
        DRAIN:   if (dout_ready && rd_last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Buffer writes, read/write counters and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_RES; i++) res_buf[i] <= '0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      overflow_err <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N_RES; i++) res_buf[i] <= '0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_valid) begin
            res_buf[0] <= acc_in;
            wr_cnt     <= IDX_W'(1);
          end
        end
        COLLECT: begin
          if (acc_valid) begin
            res_buf[wr_cnt] <= acc_in;
            if (wr_last) begin
              wr_cnt <= '0;
              rd_cnt <= '0;
            end else begin
              wr_cnt <= wr_cnt + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (dout_ready) begin
            rd_cnt <= rd_last ? '0 : rd_cnt + IDX_W'(1);
          end
          if (acc_valid) overflow_err <= 1'b1;
        end
        DONE: begin
          if (acc_valid) overflow_err <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output stage: only DRAIN presents data, saturating anything above OUT_W.
  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    dout_idx   = '0;
    dout_last  = 1'b0;
    if (state == DRAIN) begin
      dout_valid = 1'b1;
      dout       = (|rd_word[ACC_W-1:OUT_W]) ? SAT_MAX : rd_word[OUT_W-1:0];
      dout_idx   = 4'(rd_cnt);
      dout_last  = rd_last;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: directed scenarios plus randomized
// back-to-back products, compared against a saturating reference model.
module tb_result_drain;

  localparam int ACC_W = 18;
  localparam int OUT_W = 16;
  localparam int N_RES = 4;

  logic             clk;
  logic             reset;
  logic             clear;
  logic [ACC_W-1:0] acc_in;
  logic             acc_valid;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [3:0]       dout_idx;
  logic             dout_last;
  logic             busy;
  logic             done;
  logic             overflow_err;

  result_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W), .N_RES(N_RES)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .acc_in(acc_in),
    .acc_valid(acc_valid),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_idx(dout_idx),
    .dout_last(dout_last),
    .busy(busy),
    .done(done),
    .overflow_err(overflow_err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [ACC_W-1:0] stim [N_RES];
  logic [OUT_W-1:0] obs_data [$];
  logic [3:0]       obs_idx [$];
  logic             obs_last [$];
  logic [OUT_W-1:0] stall_data [$];
  logic [3:0]       stall_idx [$];
  logic             done_first;
  logic             done_second;
  logic             busy_after;
  bit               drain_timeout;

  // Reference saturation: values above the OUT_W range clamp to all-ones.
  function automatic logic [OUT_W-1:0] sat_ref(input logic [ACC_W-1:0] x);
    longint unsigned maxv = (64'd1 << OUT_W) - 64'd1;
    longint unsigned v = 64'(x);
    if (v > maxv) return OUT_W'(maxv);
    return OUT_W'(v);
  endfunction

  function automatic logic [ACC_W-1:0] rand_acc();
    if ($urandom_range(0, 1) == 1) return ACC_W'($urandom_range(0, (1 << ACC_W) - 1));
    return ACC_W'($urandom_range(0, 1000));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_RES; i++) stim[i] = rand_acc();
  endtask

  // Presents stim[] one value per capture, gap idle cycles between captures.
  task automatic feed(input int gap);
    dout_ready = 1'b0;
    for (int i = 0; i < N_RES; i++) begin
      acc_in    = stim[i];
      acc_valid = 1'b1;
      cyc();
      acc_valid = 1'b0;
      acc_in    = '0;
      if (i < N_RES - 1) begin
        for (int g = 0; g < gap; g++) cyc();
      end
    end
  endtask

  // Drives dout_ready and records every accepted transfer plus the done pulse.
  task automatic drain(input int stall_at, input int stall_len, input bit rand_ready, input bit inject);
    int  stalled = 0;
    int  cycles = 0;
    bit  got_last = 0;
    obs_data.delete();
    obs_idx.delete();
    obs_last.delete();
    stall_data.delete();
    stall_idx.delete();
    while (!got_last && cycles < 200) begin
      if (dout_valid && stall_at >= 0 && dout_idx == 4'(stall_at) && stalled < stall_len) begin
        dout_ready = 1'b0;
        stalled++;
        stall_data.push_back(dout);
        stall_idx.push_back(dout_idx);
      end else if (rand_ready) begin
        dout_ready = 1'($urandom_range(0, 1));
      end else begin
        dout_ready = 1'b1;
      end
      acc_valid = inject && (cycles == 1);
      acc_in    = ACC_W'(18'h2AAAA);
      if (dout_valid && dout_ready) begin
        obs_data.push_back(dout);
        obs_idx.push_back(dout_idx);
        obs_last.push_back(dout_last);
        if (dout_last) got_last = 1;
      end
      cyc();
      cycles++;
    end
    dout_ready    = 1'b0;
    acc_valid     = 1'b0;
    acc_in        = '0;
    drain_timeout = !got_last;
    done_first    = done;
    cyc();
    done_second   = done;
    busy_after    = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || dout_idx !== 4'd0 || dout_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || overflow_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got dout=%h v=%b idx=%0d last=%b busy=%b done=%b ovf=%b, expected all zero",
               dout, dout_valid, dout_idx, dout_last, busy, done, overflow_err);
    end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got busy=%b v=%b done=%b, expected 0 0 0", busy, dout_valid, done);
    end
  endtask

  task automatic test_basic();
    stim[0] = 18'd10; stim[1] = 18'd20; stim[2] = 18'd30; stim[3] = 18'd40;
    feed(0);
    checks++;
    if (dout_valid !== 1'b1 || busy !== 1'b1 || dout !== 16'd10 || dout_idx !== 4'd0) begin
      failures++;
      $display("[TB] FAIL basic_latency: got v=%b busy=%b dout=%0d idx=%0d, expected 1 1 10 0",
               dout_valid, busy, dout, dout_idx);
    end
    drain(-1, 0, 0, 0);
    checks++;
    if (drain_timeout || obs_data.size() != N_RES) begin
      failures++;
      $display("[TB] FAIL basic_count: got %0d transfers, expected %0d", obs_data.size(), N_RES);
    end
    for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
      checks++;
      if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i) || obs_last[i] !== (i == N_RES - 1)) begin
        failures++;
        $display("[TB] FAIL basic_data[%0d]: got %0d idx=%0d last=%b, expected %0d idx=%0d last=%b",
                 i, obs_data[i], obs_idx[i], obs_last[i], sat_ref(stim[i]), i, (i == N_RES - 1));
      end
    end
    checks++;
    if (done_first !== 1'b1 || done_second !== 1'b0 || busy_after !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done: got done=%b,%b busy_after=%b, expected 1,0 busy_after=0",
               done_first, done_second, busy_after);
    end
  endtask

  task automatic test_saturation();
    stim[0] = 18'h3FFFF; stim[1] = 18'h10000; stim[2] = 18'h0FFFF; stim[3] = 18'd5;
    feed(0);
    drain(-1, 0, 0, 0);
    checks++;
    if (drain_timeout || obs_data.size() != N_RES) begin
      failures++;
      $display("[TB] FAIL sat_count: got %0d transfers, expected %0d", obs_data.size(), N_RES);
    end
    for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
      checks++;
      if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i)) begin
        failures++;
        $display("[TB] FAIL sat_data[%0d]: got %h idx=%0d, expected %h idx=%0d",
                 i, obs_data[i], obs_idx[i], sat_ref(stim[i]), i);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    feed(0);
    drain(1, 3, 0, 0);
    checks++;
    if (stall_data.size() != 3) begin
      failures++;
      $display("[TB] FAIL bp_stall_count: got %0d stall cycles, expected 3", stall_data.size());
    end
    for (int i = 0; i < stall_data.size(); i++) begin
      checks++;
      if (stall_data[i] !== sat_ref(stim[1]) || stall_idx[i] !== 4'd1) begin
        failures++;
        $display("[TB] FAIL bp_hold[%0d]: got %h idx=%0d, expected %h idx=1",
                 i, stall_data[i], stall_idx[i], sat_ref(stim[1]));
      end
    end
    checks++;
    if (drain_timeout || obs_data.size() != N_RES) begin
      failures++;
      $display("[TB] FAIL bp_count: got %0d transfers, expected %0d", obs_data.size(), N_RES);
    end
    for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
      checks++;
      if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i) || obs_last[i] !== (i == N_RES - 1)) begin
        failures++;
        $display("[TB] FAIL bp_data[%0d]: got %h idx=%0d last=%b, expected %h idx=%0d",
                 i, obs_data[i], obs_idx[i], obs_last[i], sat_ref(stim[i]), i);
      end
    end
  endtask

  task automatic test_overflow();
    fill_random();
    feed(0);
    checks++;
    if (overflow_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_before: got %b, expected 0", overflow_err);
    end
    drain(-1, 0, 0, 1);
    checks++;
    if (overflow_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: got %b, expected 1", overflow_err);
    end
    checks++;
    if (drain_timeout || obs_data.size() != N_RES) begin
      failures++;
      $display("[TB] FAIL ovf_count: got %0d transfers, expected %0d", obs_data.size(), N_RES);
    end
    for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
      checks++;
      if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i)) begin
        failures++;
        $display("[TB] FAIL ovf_data[%0d]: got %h idx=%0d, expected %h idx=%0d",
                 i, obs_data[i], obs_idx[i], sat_ref(stim[i]), i);
      end
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    checks++;
    if (overflow_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_clear: got ovf=%b busy=%b, expected 0 0", overflow_err, busy);
    end
  endtask

  task automatic test_clear_mid();
    for (int i = 0; i < 2; i++) begin
      acc_in = rand_acc();
      acc_valid = 1'b1;
      cyc();
    end
    clear = 1'b1;
    acc_in = ACC_W'(18'h1234);
    cyc();
    clear = 1'b0;
    acc_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_idle: got busy=%b v=%b, expected 0 0", busy, dout_valid);
    end
    fill_random();
    feed(0);
    drain(-1, 0, 0, 0);
    checks++;
    if (drain_timeout || obs_data.size() != N_RES) begin
      failures++;
      $display("[TB] FAIL clear_count: got %0d transfers, expected %0d", obs_data.size(), N_RES);
    end
    for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
      checks++;
      if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i)) begin
        failures++;
        $display("[TB] FAIL clear_data[%0d]: got %h idx=%0d, expected %h idx=%0d",
                 i, obs_data[i], obs_idx[i], sat_ref(stim[i]), i);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      acc_in = ACC_W'(18'h3F000 + i);
      acc_valid = 1'b1;
      cyc();
    end
    acc_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_collect: got busy=%b v=%b, expected 0 0", busy, dout_valid);
    end
    cyc();
    reset = 1'b0;
    fill_random();
    feed(0);
    drain(-1, 0, 0, 0);
    checks++;
    if (drain_timeout || obs_data.size() != N_RES) begin
      failures++;
      $display("[TB] FAIL reset_mid_count: got %0d transfers, expected %0d", obs_data.size(), N_RES);
    end
    for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
      checks++;
      if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i)) begin
        failures++;
        $display("[TB] FAIL reset_mid_data[%0d]: got %h idx=%0d, expected %h idx=%0d",
                 i, obs_data[i], obs_idx[i], sat_ref(stim[i]), i);
      end
    end
    fill_random();
    feed(0);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== '0 || dout_idx !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_drain: got v=%b busy=%b dout=%h idx=%0d, expected 0 0 0 0",
               dout_valid, busy, dout, dout_idx);
    end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_gapped();
    fill_random();
    feed(2);
    drain(-1, 0, 0, 0);
    checks++;
    if (drain_timeout || obs_data.size() != N_RES) begin
      failures++;
      $display("[TB] FAIL gapped_count: got %0d transfers, expected %0d", obs_data.size(), N_RES);
    end
    for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
      checks++;
      if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i)) begin
        failures++;
        $display("[TB] FAIL gapped_data[%0d]: got %h idx=%0d, expected %h idx=%0d",
                 i, obs_data[i], obs_idx[i], sat_ref(stim[i]), i);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 8; p++) begin
      fill_random();
      feed($urandom_range(0, 3));
      drain(-1, 0, 1, 0);
      checks++;
      if (drain_timeout || obs_data.size() != N_RES) begin
        failures++;
        $display("[TB] FAIL b2b_count[%0d]: got %0d transfers, expected %0d", p, obs_data.size(), N_RES);
      end
      for (int i = 0; i < obs_data.size() && i < N_RES; i++) begin
        checks++;
        if (obs_data[i] !== sat_ref(stim[i]) || obs_idx[i] !== 4'(i) || obs_last[i] !== (i == N_RES - 1)) begin
          failures++;
          $display("[TB] FAIL b2b_data[%0d][%0d]: got %h idx=%0d last=%b, expected %h idx=%0d",
                   p, i, obs_data[i], obs_idx[i], obs_last[i], sat_ref(stim[i]), i);
        end
      end
      checks++;
      if (done_first !== 1'b1 || done_second !== 1'b0 || busy_after !== 1'b0 || overflow_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_status[%0d]: got done=%b,%b busy=%b ovf=%b, expected 1,0 0 0",
                 p, done_first, done_second, busy_after, overflow_err);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    acc_in     = '0;
    acc_valid  = 1'b0;
    dout_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_overflow();
    test_clear_mid();
    test_reset_mid();
    test_gapped();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter ACC_W, default 18, the MAC accumulator width.
REQ-002 SHALL have parameter OUT_W, default 16, the output data width (OUT_W < ACC_W).
REQ-003 SHALL have parameter N_RES, default 4, the number of results per matrix product, with 2 <= N_RES <= 16.
REQ-004 SHALL have port clk, input, 1 bit: all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port clear, input, 1 bit: synchronous abort and return to idle.
REQ-007 SHALL have port acc_in, input, ACC_W bits: unsigned MAC result.
REQ-008 SHALL have port acc_valid, input, 1 bit: acc_in is valid this cycle; one result per asserted cycle.
REQ-009 SHALL have port dout, output, OUT_W bits: saturated result.
REQ-010 SHALL have port dout_valid, output, 1 bit: dout is valid.
REQ-011 SHALL have port dout_ready, input, 1 bit: consumer accepts dout.
REQ-012 SHALL have port dout_idx, output, 4 bits: buffer index of the current dout.
REQ-013 SHALL have port dout_last, output, 1 bit: the current dout is index N_RES-1.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after the last transfer.
REQ-016 SHALL have port overflow_err, output, 1 bit: sticky flag for a dropped acc_valid.

Function
REQ-017 SHALL implement a state machine with states IDLE, COLLECT, DRAIN and DONE.
REQ-018 SHALL, in IDLE, on acc_valid, store acc_in into buf[0], set wr_cnt=1 and go to COLLECT.
REQ-019 SHALL, in COLLECT, on acc_valid, store acc_in into buf[wr_cnt] and increment wr_cnt.
REQ-020 SHALL, when the stored entry is index N_RES-1, go to DRAIN on the same edge and set rd_cnt=0.
REQ-021 SHALL hold wr_cnt and state in COLLECT while acc_valid is low, with no timeout.
REQ-022 SHALL keep dout_valid=1 throughout DRAIN, with dout=sat(buf[rd_cnt]), dout_idx=rd_cnt and dout_last=(rd_cnt==N_RES-1).
REQ-023 SHALL complete a transfer on each cycle with dout_valid && dout_ready; on transfer rd_cnt increments, and when dout_last is set the block goes to DONE.
REQ-024 SHALL hold dout, dout_idx and dout_valid stable while dout_ready is low.
REQ-025 SHALL compute sat(x) as x when x <= 2^OUT_W-1, otherwise 2^OUT_W-1; there is no wrap-around.
REQ-026 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-027 SHALL drop any acc_valid that arrives in DRAIN or DONE, leave the buffer unchanged and set overflow_err.
REQ-028 SHALL let clear take priority over all other events: the block goes to IDLE, wr_cnt=0, rd_cnt=0, overflow_err=0, and the buffer is zeroed; acc_valid in the same cycle is ignored.
REQ-029 SHALL drive dout_valid=0, dout_last=0 and done=0, with dout and dout_idx at 0, in every state other than DRAIN (done is high only in DONE).
REQ-030 SHALL have latency from the capture edge of the last result to dout_valid high of 1 cycle.
REQ-031 SHALL allow back-to-back operation: the first acc_valid of the next product is accepted in the cycle after done.

Reset
REQ-032 SHALL, on reset, set state=IDLE, wr_cnt=0, rd_cnt=0, all buffer entries to 0, and outputs dout=0, dout_valid=0, dout_idx=0, dout_last=0, busy=0, done=0, overflow_err=0.
REQ-033 SHALL, on reset asserted mid-COLLECT or mid-DRAIN, abandon the operation immediately; after reset releases, the first acc_valid is stored at buf[0].

Verification
REQ-034 Bench SHALL apply acc_valid for 4 cycles with acc_in=10,20,30,40 and dout_ready=1, and check that dout gives 10,20,30,40 with dout_idx 0..3, dout_last only on 40, done pulsing once, and busy low after.
REQ-035 Bench SHALL apply acc_in=0x3FFFF, 0x10000, 0x0FFFF, 5, and check that dout gives 0xFFFF, 0xFFFF, 0xFFFF, 5.
REQ-036 Bench SHALL drive dout_ready low for 3 cycles at idx 1, and check that dout and idx are held with no loss or duplication.
REQ-037 Bench SHALL apply acc_valid in DRAIN, and check that overflow_err=1, the output sequence is unchanged, and clear returns overflow_err to 0.
REQ-038 Bench SHALL assert reset after 2 captures, then apply 4 new captures, and check that only the new values appear.
REQ-039 Bench SHALL apply gapped acc_valid in COLLECT, one capture every 3 cycles, and check that all 4 values are stored in order.
